// File: rtl/pico_mailbox_duplex_pkg.sv
// Shared constants for the dual-Pico mailbox: register offsets, STAT/CTRL bit
// positions and the per-FIFO flag-clear vector layout.
package pico_mailbox_pkg;

  localparam int unsigned OFS_TX_DATA  = 0;
  localparam int unsigned OFS_RX_DATA  = 1;
  localparam int unsigned OFS_STAT     = 2;
  localparam int unsigned OFS_RX_COUNT = 3;
  localparam int unsigned OFS_CTRL     = 4;

  localparam int unsigned STAT_TX_FULL      = 0;
  localparam int unsigned STAT_RX_EMPTY     = 1;
  localparam int unsigned STAT_TX_EMPTY     = 2;
  localparam int unsigned STAT_TX_OVERFLOW  = 3;
  localparam int unsigned STAT_RX_UNDERFLOW = 4;

  localparam int unsigned CTRL_FLUSH     = 0;
  localparam int unsigned CTRL_CLR_FLAGS = 1;

  // Overflow belongs to the writer and underflow to the reader, so each is cleared separately
  localparam int unsigned CLR_OVERFLOW  = 0;
  localparam int unsigned CLR_UNDERFLOW = 1;

  function automatic logic [7:0] port_addr(input logic [7:0] base, input int unsigned ofs);
    return base + 8'(ofs);
  endfunction

endpackage

// File: rtl/pico_mailbox_duplex_if.sv
// One KCPSM6 port bus; the core is master, the mailbox is slave.
interface pico_mailbox_duplex_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       write_strobe;
  logic       read_strobe;
  logic [7:0] in_port;

  modport master (output port_id, output out_port, output write_strobe,
                  output read_strobe, input in_port);
  modport slave  (input port_id, input out_port, input write_strobe,
                  input read_strobe, output in_port);
endinterface

// File: rtl/pico_mailbox_duplex_fifo.sv
// One mailbox direction: circular byte FIFO with sticky overflow/underflow,
// flush and a registered occupancy-threshold interrupt.
module mailbox_fifo
  import pico_mailbox_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned IRQ_LEVEL  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic [7:0]          din,
  input  logic                pop,
  input  logic                flush,
  input  logic [1:0]          clr_flags,
  output logic [7:0]          dout,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty,
  output logic                overflow,
  output logic                underflow,
  output logic                irq
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  ovf_evt;
  logic                  unf_evt;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  assign unf_evt = pop && empty;
  // A pop frees the slot a full-FIFO push needs; flush discards the push silently
  assign push_ok = push && !flush && (!full || pop);
  assign ovf_evt = push && !flush && full && !pop;
  assign dout    = empty ? 8'h00 : mem[rd_ptr];

  // Storage is left uninitialised; it is only visible while non-empty
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      irq       <= 1'b0;
    end else begin
      irq <= (count >= CW'(IRQ_LEVEL));
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
        if (pop_ok)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        case ({push_ok, pop_ok})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: ;
        endcase
      end
      // A same-cycle event beats a clear
      overflow  <= (overflow  && !clr_flags[CLR_OVERFLOW])  || ovf_evt;
      underflow <= (underflow && !clr_flags[CLR_UNDERFLOW]) || unf_evt;
    end
  end

endmodule

// File: rtl/pico_mailbox_duplex.sv
// Full-duplex mailbox between two KCPSM6 cores: per-side port decode and
// combinational read muxes around an A->B and a B->A FIFO.
module pico_mailbox_duplex
  import pico_mailbox_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [7:0]  PORT_BASE  = 8'd10,
  parameter int unsigned IRQ_LEVEL  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  pico_mailbox_duplex_if.slave  a,
  pico_mailbox_duplex_if.slave  b,
  output logic                  irq_a,
  output logic                  irq_b
);

  localparam logic [7:0] P_TX    = port_addr(PORT_BASE, OFS_TX_DATA);
  localparam logic [7:0] P_RX    = port_addr(PORT_BASE, OFS_RX_DATA);
  localparam logic [7:0] P_STAT  = port_addr(PORT_BASE, OFS_STAT);
  localparam logic [7:0] P_COUNT = port_addr(PORT_BASE, OFS_RX_COUNT);
  localparam logic [7:0] P_CTRL  = port_addr(PORT_BASE, OFS_CTRL);

  logic a_push, a_pop, a_ctrl, a_flush, a_clr;
  logic b_push, b_pop, b_ctrl, b_flush, b_clr;

  logic [7:0]          ab_dout, ba_dout;
  logic [DEPTH_LOG2:0] ab_count, ba_count;
  logic ab_full, ab_empty, ab_ovf, ab_unf;
  logic ba_full, ba_empty, ba_ovf, ba_unf;

  assign a_push  = a.write_strobe && (a.port_id == P_TX);
  assign a_ctrl  = a.write_strobe && (a.port_id == P_CTRL);
  assign a_pop   = a.read_strobe  && (a.port_id == P_RX);
  assign a_flush = a_ctrl && a.out_port[CTRL_FLUSH];
  assign a_clr   = a_ctrl && a.out_port[CTRL_CLR_FLAGS];

  assign b_push  = b.write_strobe && (b.port_id == P_TX);
  assign b_ctrl  = b.write_strobe && (b.port_id == P_CTRL);
  assign b_pop   = b.read_strobe  && (b.port_id == P_RX);
  assign b_flush = b_ctrl && b.out_port[CTRL_FLUSH];
  assign b_clr   = b_ctrl && b.out_port[CTRL_CLR_FLAGS];

  mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .IRQ_LEVEL(IRQ_LEVEL)) u_a2b (
    .clk(clk), .reset(reset),
    .push(a_push), .din(a.out_port), .pop(b_pop), .flush(a_flush),
    .clr_flags({b_clr, a_clr}),
    .dout(ab_dout), .count(ab_count), .full(ab_full), .empty(ab_empty),
    .overflow(ab_ovf), .underflow(ab_unf), .irq(irq_b)
  );

  mailbox_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .IRQ_LEVEL(IRQ_LEVEL)) u_b2a (
    .clk(clk), .reset(reset),
    .push(b_push), .din(b.out_port), .pop(a_pop), .flush(b_flush),
    .clr_flags({a_clr, b_clr}),
    .dout(ba_dout), .count(ba_count), .full(ba_full), .empty(ba_empty),
    .overflow(ba_ovf), .underflow(ba_unf), .irq(irq_a)
  );

  // Side A read mux: own TX is a2b, own RX is b2a
  always_comb begin
    a.in_port = 8'h00;
    if (a.port_id == P_RX) begin
      a.in_port = ba_dout;
    end else if (a.port_id == P_STAT) begin
      a.in_port[STAT_TX_FULL]      = ab_full;
      a.in_port[STAT_RX_EMPTY]     = ba_empty;
      a.in_port[STAT_TX_EMPTY]     = ab_empty;
      a.in_port[STAT_TX_OVERFLOW]  = ab_ovf;
      a.in_port[STAT_RX_UNDERFLOW] = ba_unf;
    end else if (a.port_id == P_COUNT) begin
      a.in_port = 8'(ba_count);
    end
  end

  // Side B read mux: own TX is b2a, own RX is a2b
  always_comb begin
    b.in_port = 8'h00;
    if (b.port_id == P_RX) begin
      b.in_port = ab_dout;
    end else if (b.port_id == P_STAT) begin
      b.in_port[STAT_TX_FULL]      = ba_full;
      b.in_port[STAT_RX_EMPTY]     = ab_empty;
      b.in_port[STAT_TX_EMPTY]     = ba_empty;
      b.in_port[STAT_TX_OVERFLOW]  = ba_ovf;
      b.in_port[STAT_RX_UNDERFLOW] = ab_unf;
    end else if (b.port_id == P_COUNT) begin
      b.in_port = 8'(ab_count);
    end
  end

endmodule

// File: tb/tb_pico_mailbox_duplex.sv
// Directed and randomised bench for pico_mailbox_duplex, checked against a
// queue-based mailbox model on every cycle plus hand-computed expectations.
module tb_pico_mailbox_duplex;

  localparam int unsigned DL2   = 2;
  localparam int          DEPTH = 4;
  localparam int          LVL   = 1;
  localparam logic [7:0]  BASE  = 8'd10;

  logic clk = 1'b0;
  logic reset;
  logic irq_a, irq_b;

  pico_mailbox_duplex_if a ();
  pico_mailbox_duplex_if b ();

  pico_mailbox_duplex #(.DEPTH_LOG2(DL2), .PORT_BASE(BASE), .IRQ_LEVEL(LVL)) dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .irq_a(irq_a), .irq_b(irq_b)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %02h, expected %02h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] q_ab[$];
  logic [7:0] q_ba[$];
  logic ovf_a, unf_a, ovf_b, unf_b, irqm_a, irqm_b;
  logic valid = 1'b0;

  function automatic logic [7:0] exp_port(input logic [7:0] id, input int tx_n, input int rx_n,
                                          input logic [7:0] head, input logic ovf, input logic unf);
    if (id == BASE + 8'd1) return (rx_n > 0) ? head : 8'h00;
    if (id == BASE + 8'd2) return {3'b000, unf, ovf, tx_n == 0, rx_n == 0, tx_n == DEPTH};
    if (id == BASE + 8'd3) return 8'(rx_n);
    return 8'h00;
  endfunction

  initial begin : compare
    logic pa, pb, ra, rb, fa, fb, ca, cb, oe, ue;
    forever begin
      @(negedge clk);
      if (valid) begin
        check("a_in_port", a.in_port, exp_port(a.port_id, q_ab.size(), q_ba.size(),
              (q_ba.size() > 0) ? q_ba[0] : 8'h00, ovf_a, unf_a));
        check("b_in_port", b.in_port, exp_port(b.port_id, q_ba.size(), q_ab.size(),
              (q_ab.size() > 0) ? q_ab[0] : 8'h00, ovf_b, unf_b));
        check("irq_a", irq_a, irqm_a);
        check("irq_b", irq_b, irqm_b);
      end
      if (reset) begin
        q_ab.delete(); q_ba.delete();
        {ovf_a, unf_a, ovf_b, unf_b, irqm_a, irqm_b} = '0;
        valid = 1'b1;
      end else if (valid) begin
        pa = a.write_strobe && a.port_id == BASE;
        pb = b.write_strobe && b.port_id == BASE;
        ra = a.read_strobe  && a.port_id == BASE + 8'd1;
        rb = b.read_strobe  && b.port_id == BASE + 8'd1;
        fa = a.write_strobe && a.port_id == BASE + 8'd4 && a.out_port[0];
        fb = b.write_strobe && b.port_id == BASE + 8'd4 && b.out_port[0];
        ca = a.write_strobe && a.port_id == BASE + 8'd4 && a.out_port[1];
        cb = b.write_strobe && b.port_id == BASE + 8'd4 && b.out_port[1];
        irqm_a = (q_ba.size() >= LVL);
        irqm_b = (q_ab.size() >= LVL);
        // A -> B
        oe = 1'b0; ue = 1'b0;
        if (rb) begin
          if (q_ab.size() == 0) ue = 1'b1; else void'(q_ab.pop_front());
        end
        if (pa && !fa) begin
          if (q_ab.size() < DEPTH) q_ab.push_back(a.out_port); else oe = 1'b1;
        end
        if (fa) q_ab.delete();
        ovf_a = (ovf_a && !ca) || oe;
        unf_b = (unf_b && !cb) || ue;
        // B -> A
        oe = 1'b0; ue = 1'b0;
        if (ra) begin
          if (q_ba.size() == 0) ue = 1'b1; else void'(q_ba.pop_front());
        end
        if (pb && !fb) begin
          if (q_ba.size() < DEPTH) q_ba.push_back(b.out_port); else oe = 1'b1;
        end
        if (fb) q_ba.delete();
        ovf_b = (ovf_b && !cb) || oe;
        unf_a = (unf_a && !ca) || ue;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [7:0] aid, input logic [7:0] ad, input logic aw, input logic ar,
                       input logic [7:0] bid, input logic [7:0] bd, input logic bw, input logic br,
                       input logic rst = 1'b0);
    @(posedge clk); #1;
    a.port_id = aid; a.out_port = ad; a.write_strobe = aw; a.read_strobe = ar;
    b.port_id = bid; b.out_port = bd; b.write_strobe = bw; b.read_strobe = br;
    reset = rst;
  endtask

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    check(name, act, exp);
  endtask

  function automatic logic [7:0] rnd_id();
    case ($urandom_range(0, 9))
      0, 1, 2: return BASE;
      3, 4, 5: return BASE + 8'd1;
      6:       return BASE + 8'd2;
      7:       return BASE + 8'd3;
      8:       return BASE + 8'd4;
      default: return ($urandom_range(0, 1) != 0) ? BASE + 8'd5 : BASE - 8'd1;
    endcase
  endfunction

  initial begin : driver
    logic [7:0] ida, idb;
    int ka, kb;
    reset = 1'b1;
    a.port_id = '0; a.out_port = '0; a.write_strobe = 1'b0; a.read_strobe = 1'b0;
    b.port_id = '0; b.out_port = '0; b.write_strobe = 1'b0; b.read_strobe = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);

    // 1: reset state
    drive(12, 0, 0, 0, 0, 0, 0, 0); #2; lit("t1_a_stat", a.in_port, 8'h06);
    drive(13, 0, 0, 0, 0, 0, 0, 0); #2; lit("t1_a_count", a.in_port, 8'h00); lit("t1_irq_b", irq_b, 1'b0);

    // 2: two bytes A->B
    drive(10, 8'hD3, 1, 0, 0, 0, 0, 0);
    drive(10, 8'hAB, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 13, 0, 0, 0); #2; lit("t2_b_count", b.in_port, 8'h02); lit("t2_irq_b", irq_b, 1'b1);
    drive(0, 0, 0, 0, 11, 0, 0, 1); #2; lit("t2_rd0", b.in_port, 8'hD3);
    drive(0, 0, 0, 0, 11, 0, 0, 1); #2; lit("t2_rd1", b.in_port, 8'hAB);
    drive(0, 0, 0, 0, 13, 0, 0, 0); #2; lit("t2_b_count0", b.in_port, 8'h00); lit("t2_irq_hold", irq_b, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  #2; lit("t2_irq_drop", irq_b, 1'b0);

    // 3: overflow then underflow
    for (int i = 1; i <= 5; i++) drive(10, 8'(i), 1, 0, 0, 0, 0, 0);
    drive(12, 0, 0, 0, 0, 0, 0, 0); #2; lit("t3_a_stat", a.in_port, 8'h0B);
    for (int i = 1; i <= 5; i++) begin
      drive(0, 0, 0, 0, 11, 0, 0, 1); #2; lit("t3_drain", b.in_port, (i == 5) ? 8'h00 : 8'(i));
    end
    drive(0, 0, 0, 0, 12, 0, 0, 0); #2; lit("t3_b_stat", b.in_port, 8'h16);

    // 4: push into full FIFO alongside a pop
    drive(14, 8'h02, 1, 0, 14, 8'h02, 1, 0);
    for (int i = 0; i < 4; i++) drive(10, 8'h11 + 8'(i), 1, 0, 0, 0, 0, 0);
    drive(10, 8'h55, 1, 0, 11, 0, 0, 1); #2; lit("t4_pop_head", b.in_port, 8'h11);
    drive(12, 0, 0, 0, 13, 0, 0, 0); #2; lit("t4_a_stat", a.in_port, 8'h03); lit("t4_b_count", b.in_port, 8'h04);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 11, 0, 0, 1); #2; lit("t4_drain", b.in_port, (i == 3) ? 8'h55 : 8'h12 + 8'(i));
    end

    // 5: flush discards queued bytes, flags survive until cleared
    drive(10, 8'h31, 1, 0, 0, 0, 0, 0);
    drive(10, 8'h32, 1, 0, 0, 0, 0, 0);
    drive(10, 8'h33, 1, 0, 0, 0, 0, 0);
    drive(10, 8'h77, 1, 0, 0, 0, 0, 0);
    drive(14, 8'h01, 1, 0, 0, 0, 0, 0);
    drive(12, 0, 0, 0, 13, 0, 0, 0); #2; lit("t5_b_count", b.in_port, 8'h00); lit("t5_a_stat", a.in_port, 8'h06);
    drive(0, 0, 0, 0, 11, 0, 0, 1); #2; lit("t5_lost", b.in_port, 8'h00);
    drive(0, 0, 0, 0, 12, 0, 0, 0); #2; lit("t5_b_unf", b.in_port, 8'h16);
    drive(0, 0, 0, 0, 14, 8'h02, 1, 0);
    drive(0, 0, 0, 0, 12, 0, 0, 0); #2; lit("t5_b_clr", b.in_port, 8'h06);

    // 6: bidirectional traffic with a mid-transfer reset
    for (int i = 0; i < 6; i++) drive(10, 8'(i), 1, 0, 10, 8'hF0 + 8'(i), 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
    drive(12, 0, 0, 0, 12, 0, 0, 0); #2;
    lit("t6_a_stat", a.in_port, 8'h06); lit("t6_b_stat", b.in_port, 8'h06);
    lit("t6_irq_a", irq_a, 1'b0); lit("t6_irq_b", irq_b, 1'b0);
    drive(13, 0, 0, 0, 13, 0, 0, 0); #2; lit("t6_a_count", a.in_port, 8'h00); lit("t6_b_count", b.in_port, 8'h00);
    drive(10, 8'hC6, 1, 0, 10, 8'hC6, 1, 0);
    drive(11, 0, 0, 1, 11, 0, 0, 1); #2; lit("t6_a_rx", a.in_port, 8'hC6); lit("t6_b_rx", b.in_port, 8'hC6);

    // Random traffic on both sides
    for (int n = 0; n < 3000; n++) begin
      ida = rnd_id(); idb = rnd_id();
      ka = $urandom_range(0, 2); kb = $urandom_range(0, 2);
      drive(ida, 8'($urandom), ka == 1, ka == 2, idb, 8'($urandom), kb == 1, kb == 2,
            $urandom_range(0, 199) == 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
